mem_boot_arbiter: RTL and testbench

MEM_BOOT_ARBITER -- requirements
Module: mem_boot_arbiter

---
 rtl/mem_boot_arbiter_pkg.sv | 26 ++
 rtl/mem_boot_arbiter.sv | 140 ++++++++++++++
 tb/tb_mem_boot_arbiter.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_boot_arbiter_pkg.sv
// ============================================================================
// Module  : mem_boot_arbiter_pkg
// Brief   : Shared memory geometry and FSM state encoding for the boot arbiter.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_boot_arbiter_pkg;

  localparam int MEM_DEPTH = 256;
  localparam int ADDR_W    = 8;
  localparam int DATA_W    = 32;
  localparam int CNT_W     = 9;

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(MEM_DEPTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DBG  = 2'd3
  } state_e;

endpackage

`default_nettype wire

// File: rtl/mem_boot_arbiter.sv
// ============================================================================
// Module  : mem_boot_arbiter
// Brief   : Shares one block RAM between a boot loader, a debug reader and the core.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_boot_arbiter
  import mem_boot_arbiter_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              ld_start,
  input  logic              ld_valid,
  input  logic              ld_last,
  input  logic [DATA_W-1:0] ld_data,
  output logic              ld_ready,
  input  logic              dbg_req,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic              dbg_ack,
  output logic [DATA_W-1:0] dbg_rdata,
  input  logic              run_stop,
  output logic              core_rstn,
  input  logic              core_memwe,
  input  logic [ADDR_W-1:0] core_memaddr,
  input  logic [DATA_W-1:0] core_memdin,
  output logic [DATA_W-1:0] core_memdout,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout,
  output logic [1:0]        state_o,
  output logic [CNT_W-1:0]  load_count
);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    load_count_q, load_count_d;
  logic [ADDR_W-1:0]   dbg_addr_q, dbg_addr_d;
  logic                dbg_phase_q, dbg_phase_d;
  logic [DATA_W-1:0]   dbg_rdata_q, dbg_rdata_d;
  logic                ack_phase;

  assign ack_phase = (state_q == ST_DBG) && dbg_phase_q;

  always_comb begin
    state_d      = state_q;
    load_count_d = load_count_q;
    dbg_addr_d   = dbg_addr_q;
    dbg_phase_d  = dbg_phase_q;
    dbg_rdata_d  = dbg_rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (ld_start) begin
          state_d      = ST_LOAD;
          load_count_d = '0;
        end else if (dbg_req) begin
          state_d     = ST_DBG;
          dbg_addr_d  = dbg_addr;
          dbg_phase_d = 1'b0;
        end
      end
      ST_LOAD: begin
        if (ld_valid) begin
          load_count_d = load_count_q + 1'b1;
          // The 256th word ends the load even without ld_last, so the address never wraps.
          if (ld_last || (load_count_q == LAST_IDX)) begin
            state_d = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        if (run_stop) begin
          state_d = ST_IDLE;
        end
      end
      ST_DBG: begin
        if (!dbg_phase_q) begin
          dbg_phase_d = 1'b1;
        end else begin
          dbg_rdata_d = mem_dout;
          dbg_phase_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are qualified by rst so a reset cycle never writes or acknowledges.
  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_din   = '0;
    ld_ready  = 1'b0;
    core_rstn = 1'b0;
    case (state_q)
      ST_LOAD: begin
        ld_ready = ~rst;
        mem_we   = ld_valid & ~rst;
        mem_addr = load_count_q[ADDR_W-1:0];
        mem_din  = ld_data;
      end
      ST_RUN: begin
        core_rstn = ~rst;
        mem_we    = core_memwe & ~rst;
        mem_addr  = core_memaddr;
        mem_din   = core_memdin;
      end
      ST_DBG: begin
        mem_addr = dbg_addr_q;
      end
      default: ;
    endcase
  end

  assign dbg_ack      = ack_phase & ~rst;
  assign dbg_rdata    = dbg_ack ? mem_dout : dbg_rdata_q;
  assign core_memdout = mem_dout;
  assign state_o      = state_q;
  assign load_count   = load_count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      load_count_q <= '0;
      dbg_addr_q   <= '0;
      dbg_phase_q  <= 1'b0;
      dbg_rdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      load_count_q <= load_count_d;
      dbg_addr_q   <= dbg_addr_d;
      dbg_phase_q  <= dbg_phase_d;
      dbg_rdata_q  <= dbg_rdata_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_boot_arbiter.sv
// ============================================================================
// Module  : tb_mem_boot_arbiter
// Brief   : Randomized scoreboard bench for mem_boot_arbiter with a RAM model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_boot_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        ld_start, ld_valid, ld_last, ld_ready;
  logic [31:0] ld_data;
  logic        dbg_req, dbg_ack;
  logic [7:0]  dbg_addr;
  logic [31:0] dbg_rdata;
  logic        run_stop, core_rstn;
  logic        core_memwe;
  logic [7:0]  core_memaddr;
  logic [31:0] core_memdin, core_memdout;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [31:0] mem_din, mem_dout;
  logic [1:0]  state_o;
  logic [8:0]  load_count;

  always #5 clk = ~clk;

  mem_boot_arbiter dut (
    .clk(clk), .rst(rst),
    .ld_start(ld_start), .ld_valid(ld_valid), .ld_last(ld_last), .ld_data(ld_data),
    .ld_ready(ld_ready),
    .dbg_req(dbg_req), .dbg_addr(dbg_addr), .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata),
    .run_stop(run_stop), .core_rstn(core_rstn),
    .core_memwe(core_memwe), .core_memaddr(core_memaddr), .core_memdin(core_memdin),
    .core_memdout(core_memdout),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout),
    .state_o(state_o), .load_count(load_count)
  );

  // Block RAM environment: synchronous write, read-first, one cycle read latency.
  logic [31:0] ram [256];
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_din;
    mem_dout <= ram[mem_addr];
  end

  typedef struct {
    bit          is_ack;
    logic [7:0]  addr;
    logic [31:0] data;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] ref_mem [256];
  logic [31:0] dir_words [3];
  int          vectors = 0;
  int          miscompares = 0;
  int          cur_count = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every memory write and debug ack must match the oldest expectation.
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      vectors++;
      if (exp_q.size() == 0 || exp_q[0].is_ack) begin
        miscompares++;
        $display("FAIL mem_write: unexpected write addr=%h data=%h", mem_addr, mem_din);
      end else begin
        if (mem_addr !== exp_q[0].addr || mem_din !== exp_q[0].data) begin
          miscompares++;
          $display("FAIL mem_write: got addr=%h data=%h expected addr=%h data=%h",
                   mem_addr, mem_din, exp_q[0].addr, exp_q[0].data);
        end
        void'(exp_q.pop_front());
      end
    end
    if (dbg_ack === 1'b1) begin
      vectors++;
      if (exp_q.size() == 0 || !exp_q[0].is_ack) begin
        miscompares++;
        $display("FAIL dbg_ack: unexpected ack rdata=%h", dbg_rdata);
      end else begin
        if (dbg_rdata !== exp_q[0].data) begin
          miscompares++;
          $display("FAIL dbg_rdata: got %h expected %h", dbg_rdata, exp_q[0].data);
        end
        void'(exp_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input int n, input bit use_last, input int gap_pct, input bit dir);
    int acc = 0;
    int cyc = 0;
    bit done = 0;
    bit v;
    ld_start = 1; dbg_req = 1; dbg_addr = 8'($urandom);
    tick();
    ld_start = 0; dbg_req = 0;
    check("load_enter_state", 32'(state_o), 32'd1);
    check("load_count_clear", 32'(load_count), 32'd0);
    while (!done && cyc < 4000) begin
      v = (gap_pct < 0) ? (cyc % 2 == 0) : ($urandom_range(99) >= gap_pct);
      ld_valid = v;
      ld_data  = (dir && acc < 3) ? dir_words[acc] : $urandom;
      ld_last  = v && use_last && (acc == n - 1);
      ld_start = 1'($urandom_range(1));
      dbg_req  = 1'($urandom_range(1));
      if (v) begin
        exp_q.push_back('{1'b0, acc[7:0], ld_data});
        ref_mem[acc[7:0]] = ld_data;
        acc++;
        if (ld_last || acc == 256) done = 1;
      end else begin
        #1;
        check("gap_no_write", 32'(mem_we), 32'd0);
      end
      tick();
      cyc++;
    end
    if (!done) check("load_timeout", 32'd0, 32'd1);
    cur_count = acc;
    ld_last = 0; ld_start = 0; dbg_req = 0; core_memwe = 0;
    ld_valid = 1; ld_data = $urandom;
    check("load_to_run", 32'(state_o), 32'd2);
    check("load_count_final", 32'(load_count), 32'(acc));
    check("core_rstn_run", 32'(core_rstn), 32'd1);
    #1;
    check("no_extra_write", 32'(mem_we), 32'd0);
    check("ld_ready_run", 32'(ld_ready), 32'd0);
    tick();
    ld_valid = 0;
  endtask

  task automatic do_run(input int cycles, input bit put_deadbeef);
    logic [31:0] exp_rd;
    for (int i = 0; i < cycles; i++) begin
      core_memwe   = 1'($urandom_range(1));
      core_memaddr = 8'($urandom);
      core_memdin  = $urandom;
      if (put_deadbeef && i == 0) begin
        core_memwe = 1; core_memaddr = 8'h10; core_memdin = 32'hDEADBEEF;
      end
      dbg_req  = 1'($urandom_range(1));
      dbg_addr = 8'($urandom);
      ld_start = 1'($urandom_range(1));
      exp_rd = ref_mem[core_memaddr];
      if (core_memwe) begin
        exp_q.push_back('{1'b0, core_memaddr, core_memdin});
        ref_mem[core_memaddr] = core_memdin;
      end
      tick();
      check("core_memdout", core_memdout, exp_rd);
      check("run_hold_state", 32'(state_o), 32'd2);
    end
    core_memwe = 0; ld_start = 0; dbg_req = 0; run_stop = 1;
    tick();
    run_stop = 0;
    check("stop_state", 32'(state_o), 32'd0);
    check("stop_core_rstn", 32'(core_rstn), 32'd0);
    check("load_count_held", 32'(load_count), 32'(cur_count));
    core_memwe = 1; core_memaddr = 8'($urandom); core_memdin = $urandom;
    #1;
    check("stop_core_we_blocked", 32'(mem_we), 32'd0);
    tick();
    core_memwe = 0;
  endtask

  task automatic do_dbg(input logic [7:0] addr, input bit abort);
    dbg_req = 1; dbg_addr = addr;
    tick();
    dbg_req = 0; dbg_addr = 8'($urandom);
    check("dbg_state", 32'(state_o), 32'd3);
    if (abort) begin
      rst = 1;
      #1;
      check("dbg_abort_no_ack", 32'(dbg_ack), 32'd0);
      tick();
      rst = 0;
      cur_count = 0;
      check("dbg_abort_idle", 32'(state_o), 32'd0);
      check("dbg_abort_rdata", dbg_rdata, 32'd0);
    end else begin
      exp_q.push_back('{1'b1, addr, ref_mem[addr]});
      tick();
      check("dbg_ack_high", 32'(dbg_ack), 32'd1);
      tick();
      check("dbg_ack_one_cycle", 32'(dbg_ack), 32'd0);
      check("dbg_back_idle", 32'(state_o), 32'd0);
      tick();
      check("dbg_rdata_hold", dbg_rdata, ref_mem[addr]);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) begin
      ram[i] = '0;
      ref_mem[i] = '0;
    end
    dir_words[0] = 32'h00000013;
    dir_words[1] = 32'h00A00513;
    dir_words[2] = 32'h0000007F;
    rst = 1; ld_start = 0; ld_valid = 1; ld_last = 0; ld_data = '0;
    dbg_req = 0; dbg_addr = '0; run_stop = 0;
    core_memwe = 0; core_memaddr = '0; core_memdin = '0;
    tick(); tick();
    check("rst_state", 32'(state_o), 32'd0);
    check("rst_core_rstn", 32'(core_rstn), 32'd0);
    check("rst_load_count", 32'(load_count), 32'd0);
    check("rst_dbg_ack", 32'(dbg_ack), 32'd0);
    check("rst_dbg_rdata", dbg_rdata, 32'd0);
    check("rst_ld_ready", 32'(ld_ready), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    rst = 0; ld_valid = 0;
    tick();

    do_load(3, 1, 0, 1);
    do_run(8, 1);
    do_dbg(8'h10, 0);
    check("dbg_deadbeef", dbg_rdata, 32'hDEADBEEF);

    do_load(2, 1, -1, 0);
    do_run(4, 0);

    do_load(256, 0, 0, 0);
    do_run(4, 0);

    for (int it = 0; it < 6; it++) begin
      do_load($urandom_range(1, 40), 1, $urandom_range(0, 50), 0);
      do_run($urandom_range(3, 12), 0);
      for (int k = 0; k < 3; k++) do_dbg(8'($urandom), 0);
    end

    do_dbg(8'($urandom), 1);

    ld_start = 1;
    tick();
    ld_start = 0;
    for (int w = 0; w < 2; w++) begin
      ld_valid = 1; ld_data = $urandom;
      exp_q.push_back('{1'b0, 8'(w), ld_data});
      ref_mem[w] = ld_data;
      tick();
    end
    rst = 1; ld_valid = 1; ld_data = $urandom;
    #1;
    check("rst_load_no_write", 32'(mem_we), 32'd0);
    tick();
    rst = 0;
    cur_count = 0;
    check("rst_load_state", 32'(state_o), 32'd0);
    check("rst_load_count", 32'(load_count), 32'd0);
    check("rst_load_core_rstn", 32'(core_rstn), 32'd0);
    for (int w = 0; w < 3; w++) begin
      ld_data = $urandom;
      #1;
      check("post_rst_no_write", 32'(mem_we), 32'd0);
      tick();
    end
    ld_valid = 0;
    do_dbg(8'h01, 0);

    tick(); tick();
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
